axis_data_trim: RTL and testbench

AXIS_DATA_TRIM -- requirements
Module: axis_dataTrim

---
 rtl/axis_trim_pkg.sv | 27 ++
 rtl/axis_trim_hold.sv | 67 ++++++
 rtl/axis_data_trim.sv | 99 +++++++++
 tb/tb_axis_data_trim.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_trim_pkg.sv
// axis_trim_pkg
// Shared definitions for the AXI-Stream packet trimmer:
//   DATA_W_DEF / CNT_W_DEF : default stream data width and counter width
//   ZERO_FRAME             : all-zero reference frame, sliced to DATA_W by users
//                            (used when AXIS_DATA_TRIM_ZERO_DROP_EN is defined)
//   sat_inc()              : saturating increment on a SAT_W-bit value; callers
//                            zero-extend their counter and pass its all-ones value
package axis_trim_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    // Widest counter sat_inc() can serve (CNT_W must not exceed this).
    localparam int SAT_W  = 64;
    // Widest data bus ZERO_FRAME can be compared against.
    localparam int ZERO_W = 1024;

    localparam logic [ZERO_W-1:0] ZERO_FRAME = '0;

    // Returns v + 1, or v unchanged when v already equals the counter's
    // all-ones value.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] all_ones);
        return (v == all_ones) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/axis_trim_hold.sv
// axis_trim_hold
// One-frame hold register between the upstream and downstream streams. The
// most recent kept frame waits here until either the next kept frame arrives
// or the packet ends, so that tlast can be moved onto the last kept frame.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   s_tvalid/s_tdata/s_tlast/s_tready : upstream stream
//   kept               : classification of the frame on s_tdata this cycle
//   m_tvalid/m_tdata/m_tlast/m_tready : downstream stream
//
// Handshakes: a transfer happens on a rising edge where valid && ready. A
// producer keeps valid and its payload stable until that transfer; ready may
// change freely. Here m_tvalid depends on s_tvalid/kept, so it relies on the
// upstream source obeying the same rule.
module axis_trim_hold #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              kept,
    output logic              s_tready,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast
);

    logic [DATA_W-1:0] h_data;
    logic              h_valid;
    logic              h_last;
    logic              s_hs;
    logic              m_hs;

    // H may only be released when it is known not to be the last kept frame
    // (a kept frame is waiting) or when the packet has ended (h_last). While
    // h_last is set the input is stalled so the next packet cannot overtake.
    assign s_tready = !h_valid || (!h_last && (!kept || m_tready));
    assign m_tvalid = h_valid && (h_last || (s_tvalid && kept));
    assign m_tdata  = h_data;
    assign m_tlast  = h_last;

    assign s_hs = s_tvalid && s_tready;
    assign m_hs = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_data  <= '0;
            h_valid <= 1'b0;
            h_last  <= 1'b0;
        end else if (s_hs && kept) begin
            // s_tready guarantees H is empty or being emitted this cycle.
            h_data  <= s_tdata;
            h_valid <= 1'b1;
            h_last  <= s_tlast;
        end else if (m_hs) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
        end else if (s_hs && s_tlast && h_valid) begin
            // Dropped frame ends the packet: the held frame becomes the last.
            h_last  <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_data_trim.sv
// axis_data_trim
// Trims padded AXI-Stream packets down to at most iFrameNumMax frames, moving
// tlast onto the last frame kept. Dropped frames are accepted and discarded.
// Optional feature macro: AXIS_DATA_TRIM_ZERO_DROP_EN -- when defined, all-zero
// frames inside the limit are dropped as well.
// Ports:
//   s_axis_aclk, s_axis_aresetn : clock, asynchronous active-low reset
//   iFrameNumMax                : frames kept per packet (0 drops everything)
//   s_axis_*                    : upstream padded stream
//   m_axis_*                    : trimmed downstream stream
//   m_axis_hsked                : downstream handshake this cycle
//   oFrameCnt                   : frames in the last completed output packet
//   oDropCnt                    : saturating total of discarded input frames
module axis_data_trim
    import axis_trim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic [CNT_W-1:0]  iFrameNumMax,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_hsked,
    output logic [CNT_W-1:0]  oFrameCnt,
    output logic [CNT_W-1:0]  oDropCnt
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] idx;      // 1-based index of the frame on s_axis
    logic [CNT_W-1:0] out_cnt;  // frames emitted so far in the current output packet
    logic             kept;
    logic             s_hs;
    logic             m_hs;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_W'(v), SAT_W'(CNT_ONES)));
    endfunction

`ifdef AXIS_DATA_TRIM_ZERO_DROP_EN
    assign kept = (idx <= iFrameNumMax) && (s_axis_tdata != ZERO_FRAME[DATA_W-1:0]);
`else
    assign kept = (idx <= iFrameNumMax);
`endif

    assign s_hs         = s_axis_tvalid && s_axis_tready;
    assign m_hs         = m_axis_tvalid && m_axis_tready;
    assign m_axis_hsked = m_hs;

    axis_trim_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk      (s_axis_aclk),
        .rst_n    (s_axis_aresetn),
        .s_tvalid (s_axis_tvalid),
        .s_tdata  (s_axis_tdata),
        .s_tlast  (s_axis_tlast),
        .kept     (kept),
        .s_tready (s_axis_tready),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tdata  (m_axis_tdata),
        .m_tlast  (m_axis_tlast)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            idx       <= CNT_ONE;
            out_cnt   <= '0;
            oFrameCnt <= '0;
            oDropCnt  <= '0;
        end else begin
            if (s_hs) begin
                idx <= s_axis_tlast ? CNT_ONE : cnt_inc(idx);
            end
            if (s_hs && !kept) begin
                oDropCnt <= cnt_inc(oDropCnt);
            end
            if (m_hs) begin
                if (m_axis_tlast) begin
                    oFrameCnt <= cnt_inc(out_cnt);
                    out_cnt   <= '0;
                end else begin
                    out_cnt   <= cnt_inc(out_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_data_trim.sv
// tb_axis_data_trim
// Self-checking bench for axis_data_trim. A packet-level reference model
// derives the expected output frames and counters; a monitor collects the
// frames actually emitted and checks downstream stability under backpressure.
module tb_axis_data_trim;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;
    localparam int CW     = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CNT_W-1:0]  max_in;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_hsked;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    axis_data_trim #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .iFrameNumMax   (max_in),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tdata   (s_tdata),
        .s_axis_tlast   (s_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .m_axis_hsked   (m_hsked),
        .oFrameCnt      (frame_cnt),
        .oDropCnt       (drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0]     exp_q[$];
    logic [CW-1:0]     obs_q[$];
    logic [DATA_W-1:0] pkt[$];
    logic [CNT_W-1:0]  exp_fcnt = '0;
    logic [CNT_W-1:0]  exp_dcnt = '0;
    int                ready_mode = 0;  // 0: always ready, 1: random, 2: never
    bit                gaps = 0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- downstream ready driver ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    bit            stall_pending = 0;
    logic [CW-1:0] stall_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 0;
        end else begin
            if (stall_pending) begin
                chk("stall tvalid held", CW'(m_tvalid), CW'(1));
                chk("stall payload held", {m_tlast, m_tdata}, stall_word);
            end
            if (m_tvalid) chk("hsked", CW'(m_hsked), CW'(m_tready));
            if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
            stall_pending = m_tvalid && !m_tready;
            stall_word    = {m_tlast, m_tdata};
        end
    end

    // ---------------- reference model ----------------
    function automatic bit is_kept(input int i, input logic [CNT_W-1:0] mx);
        bit k;
        k = (i + 1) <= int'(mx);
`ifdef AXIS_DATA_TRIM_ZERO_DROP_EN
        if (pkt[i] == '0) k = 0;
`endif
        return k;
    endfunction

    // Packet rule: frames whose 1-based position is within the limit are
    // forwarded in order, tlast on the final forwarded one; the rest count
    // as drops. A packet with nothing forwarded leaves the frame count alone.
    task automatic model_pkt(input logic [CNT_W-1:0] mx);
        int kept_n = 0;
        int last_k = -1;
        for (int i = 0; i < pkt.size(); i++)
            if (is_kept(i, mx)) begin kept_n++; last_k = i; end
        for (int i = 0; i < pkt.size(); i++)
            if (is_kept(i, mx)) exp_q.push_back({(i == last_k), pkt[i]});
        exp_dcnt += CNT_W'(pkt.size() - kept_n);
        if (kept_n > 0) exp_fcnt = CNT_W'(kept_n);
    endtask

    // ---------------- drivers ----------------
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic l);
        bit done = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (s_tready) begin done = 1; break; end
        end
        if (!done) chk("s handshake timeout", CW'(0), CW'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [CNT_W-1:0] mx);
        max_in = mx;
        for (int i = 0; i < pkt.size(); i++) send_frame(pkt[i], (i == pkt.size() - 1));
    endtask

    task automatic run_pkt(input logic [CNT_W-1:0] mx);
        model_pkt(mx);
        send_pkt(mx);
    endtask

    task automatic check_drain(input string tag);
        int n;
        for (int c = 0; c < 3000 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " frame count"}, CW'(obs_q.size()), CW'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, " frame"}, obs_q[i], exp_q[i]);
        chk({tag, " oFrameCnt"}, CW'(frame_cnt), CW'(exp_fcnt));
        chk({tag, " oDropCnt"}, CW'(drop_cnt), CW'(exp_dcnt));
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [DATA_W-1:0] rand_data(input bit allow_zero);
        if (allow_zero && $urandom_range(0, 4) == 0) return '0;
        return {$urandom, ($urandom | 32'h1)};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        max_in   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_tvalid", CW'(m_tvalid), CW'(0));
        chk("reset m_tdata", CW'(m_tdata), CW'(0));
        chk("reset m_tlast", CW'(m_tlast), CW'(0));
        chk("reset oFrameCnt", CW'(frame_cnt), CW'(0));
        chk("reset oDropCnt", CW'(drop_cnt), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset s_tready", CW'(s_tready), CW'(1));
        @(posedge clk);
        #1;

        // Max=3, A,B,C,0,0
        pkt = '{64'hA, 64'hB, 64'hC, 64'h0, 64'h0};
        run_pkt(3);
        check_drain("max3 trim");

        // Max=4, two-frame packet passes unchanged
        pkt = '{64'hD, 64'hE};
        run_pkt(4);
        check_drain("max4 short");

        // Max=0 drops everything
        pkt.delete();
        repeat (3) pkt.push_back(rand_data(0));
        run_pkt(0);
        check_drain("max0 drop");

        // Backpressure with back-to-back 5-frame packets
        ready_mode = 1;
        for (int p = 0; p < 4; p++) begin
            pkt.delete();
            repeat (5) pkt.push_back(rand_data(0));
            run_pkt(3);
        end
        check_drain("b2b backpressure");

        // Randomised packets, limits and ready patterns
        gaps = 1;
        for (int p = 0; p < 14; p++) begin
            ready_mode = int'($urandom_range(0, 1));
            pkt.delete();
            repeat ($urandom_range(1, 8)) pkt.push_back(rand_data(1));
            run_pkt(CNT_W'($urandom_range(0, 6)));
            check_drain("random pkt");
        end
        gaps = 0;
        ready_mode = 0;

`ifdef AXIS_DATA_TRIM_ZERO_DROP_EN
        // Zero frames inside the limit are dropped
        pkt = '{64'hA, 64'h0, 64'hB, 64'h0};
        run_pkt(4);
        check_drain("zero drop");
`endif

        // Reset while H holds a frame marked last
        ready_mode = 2;
        pkt = '{64'hF00D, 64'hBEEF};
        send_pkt(1);
        repeat (2) @(posedge clk);
        #1;
        chk("held s_tready low", CW'(s_tready), CW'(0));
        chk("held m_tvalid", CW'(m_tvalid), CW'(1));
        chk("held payload", {m_tlast, m_tdata}, {1'b1, 64'hF00D});
        rst_n = 1'b0;
        #1;
        chk("async reset m_tvalid", CW'(m_tvalid), CW'(0));
        chk("async reset m_tdata", CW'(m_tdata), CW'(0));
        chk("async reset m_tlast", CW'(m_tlast), CW'(0));
        chk("async reset oDropCnt", CW'(drop_cnt), CW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_mode = 0;
        exp_fcnt   = '0;
        exp_dcnt   = '0;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("re-reset s_tready", CW'(s_tready), CW'(1));
        @(posedge clk);
        #1;
        pkt = '{64'h1234};
        run_pkt(1);
        check_drain("after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
